// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared types and constants for the instruction/data memory port arbiter.
//   state_e  : arbiter FSM states
//   grant_e  : which requester owns (or last owned) the bridge port
//   RESP_OKAY: AXI OKAY response code, also the reset value of the response registers
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GNT_I,
    GNT_D,
    RESP
  } state_e;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } grant_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the fetch requester, data requester and bridge-side
// signals of the memory port arbiter.
//   modport master : arbiter view (drives completions to requesters, requests to bridge)
//   modport slave  : environment view (requesters and AXI-lite bridge)
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  localparam int STRB_W = DATA_W / 8;

  // instruction-fetch requester (read-only)
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_valid;
  logic [1:0]        i_resp;

  // data requester (read/write)
  logic              d_ren;
  logic              d_wen;
  logic [ADDR_W-1:0] d_addr;
  logic [STRB_W-1:0] d_wmask;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;
  logic [1:0]        d_resp;

  // AXI-lite master bridge port
  logic [ADDR_W-1:0] address_mem;
  logic              ren_mem;
  logic              wen_mem;
  logic [STRB_W-1:0] wmask_mem;
  logic [DATA_W-1:0] wdata_mem;
  logic [DATA_W-1:0] rdata_mem;
  logic              valid_mem;
  logic [1:0]        resp_mem;

  modport master (
    input  i_req, i_addr, d_ren, d_wen, d_addr, d_wmask, d_wdata,
    input  rdata_mem, valid_mem, resp_mem,
    output i_rdata, i_valid, i_resp, d_rdata, d_valid, d_resp,
    output address_mem, ren_mem, wen_mem, wmask_mem, wdata_mem
  );

  modport slave (
    output i_req, i_addr, d_ren, d_wen, d_addr, d_wmask, d_wdata,
    output rdata_mem, valid_mem, resp_mem,
    input  i_rdata, i_valid, i_resp, d_rdata, d_valid, d_resp,
    input  address_mem, ren_mem, wen_mem, wmask_mem, wdata_mem
  );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// mem_arb_pick: combinational two-way selector between the fetch and data requesters.
//   i_req_i      : fetch request pending
//   d_active_i   : data read or write pending
//   last_grant_i : side granted most recently
//   grant_i_o    : fetch side wins
//   grant_d_o    : data side wins
// FAIR=1 alternates on ties (side other than last_grant); FAIR=0 gives ties to data.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic   i_req_i,
  input  logic   d_active_i,
  input  grant_e last_grant_i,
  output logic   grant_i_o,
  output logic   grant_d_o
);

  always_comb begin
    grant_i_o = 1'b0;
    grant_d_o = 1'b0;
    if (i_req_i && d_active_i) begin
      if (FAIR && (last_grant_i == GRANT_D)) grant_i_o = 1'b1;
      else                                   grant_d_o = 1'b1;
    end else if (i_req_i) begin
      grant_i_o = 1'b1;
    end else if (d_active_i) begin
      grant_d_o = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single AXI-lite bridge port between the fetch ("i")
// and data ("d") requesters of the CPU pipeline.
//   clk  : single clock
//   rstn : synchronous active-low reset
//   bus  : requester and bridge signals (mem_port_arbiter_if.master)
// A granted request is registered onto the bridge and held until valid_mem; the
// winner then sees a one-cycle valid with rdata/resp in the RESP state.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter bit FAIR   = 1'b1
) (
  input logic                clk,
  input logic                rstn,
  mem_port_arbiter_if.master bus
);

  localparam int STRB_W = DATA_W / 8;

  state_e            state_q, state_d;
  grant_e            last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ren_q, ren_d;
  logic              wen_q, wen_d;
  logic [STRB_W-1:0] wmask_q, wmask_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [1:0]        i_resp_q, i_resp_d;
  logic [1:0]        d_resp_q, d_resp_d;

  logic d_active;
  logic grant_i;
  logic grant_d;
  logic i_done;
  logic d_done;

  assign d_active = bus.d_ren | bus.d_wen;

  mem_arb_pick #(.FAIR(FAIR)) u_pick (
    .i_req_i      (bus.i_req),
    .d_active_i   (d_active),
    .last_grant_i (last_grant_q),
    .grant_i_o    (grant_i),
    .grant_d_o    (grant_d)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    ren_d        = ren_q;
    wen_d        = wen_q;
    wmask_d      = wmask_q;
    wdata_d      = wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_resp_d     = i_resp_q;
    d_resp_d     = d_resp_q;
    case (state_q)
      IDLE: begin
        if (grant_i) begin
          state_d      = GNT_I;
          last_grant_d = GRANT_I;
          addr_d       = bus.i_addr;
          ren_d        = 1'b1;
          wen_d        = 1'b0;
          wmask_d      = '0;
          wdata_d      = '0;
        end else if (grant_d) begin
          state_d      = GNT_D;
          last_grant_d = GRANT_D;
          addr_d       = bus.d_addr;
          // a simultaneous read+write request is issued as the write
          ren_d        = bus.d_ren & ~bus.d_wen;
          wen_d        = bus.d_wen;
          wmask_d      = bus.d_wmask;
          wdata_d      = bus.d_wdata;
        end
      end
      // wen_mem stays high through the valid_mem cycle: the bridge picks bresp vs rresp from it
      GNT_I: begin
        if (bus.valid_mem) begin
          i_rdata_d = bus.rdata_mem;
          ren_d     = 1'b0;
          wen_d     = 1'b0;
          state_d   = RESP;
        end
      end
      GNT_D: begin
        if (bus.valid_mem) begin
          d_rdata_d = bus.rdata_mem;
          ren_d     = 1'b0;
          wen_d     = 1'b0;
          state_d   = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (last_grant_q == GRANT_I) i_resp_d = bus.resp_mem;
        else                         d_resp_d = bus.resp_mem;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_I;
      addr_q       <= '0;
      ren_q        <= 1'b0;
      wen_q        <= 1'b0;
      wmask_q      <= '0;
      wdata_q      <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_resp_q     <= RESP_OKAY;
      d_resp_q     <= RESP_OKAY;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      ren_q        <= ren_d;
      wen_q        <= wen_d;
      wmask_q      <= wmask_d;
      wdata_q      <= wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      i_resp_q     <= i_resp_d;
      d_resp_q     <= d_resp_d;
    end
  end

  // last_grant doubles as the current owner while in RESP
  assign i_done = (state_q == RESP) && (last_grant_q == GRANT_I);
  assign d_done = (state_q == RESP) && (last_grant_q == GRANT_D);

  assign bus.address_mem = addr_q;
  assign bus.ren_mem     = ren_q;
  assign bus.wen_mem     = wen_q;
  assign bus.wmask_mem   = wmask_q;
  assign bus.wdata_mem   = wdata_q;
  assign bus.i_rdata     = i_rdata_q;
  assign bus.d_rdata     = d_rdata_q;
  assign bus.i_valid     = i_done;
  assign bus.d_valid     = d_done;
  // resp_mem is already updated by the bridge during RESP; pass it through, then hold
  assign bus.i_resp      = i_done ? bus.resp_mem : i_resp_q;
  assign bus.d_resp      = d_done ? bus.resp_mem : d_resp_q;

  a_rw_exclusive: assert property (@(posedge clk) disable iff (!rstn)
    !((state_q == IDLE) && bus.d_ren && bus.d_wen))
    else $warning("mem_port_arbiter: d_ren and d_wen both high, issuing the write");

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FAIR(1'b1)) dut_a (
    .clk (clk), .rstn (rstn), .bus (bus_a.master));
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FAIR(1'b0)) dut_b (
    .clk (clk), .rstn (rstn), .bus (bus_b.master));

  function automatic logic [271:0] outs(input bit sel);
    if (sel)
      return {bus_b.address_mem, bus_b.ren_mem, bus_b.wen_mem, bus_b.wmask_mem, bus_b.wdata_mem,
              bus_b.i_rdata, bus_b.i_valid, bus_b.i_resp, bus_b.d_rdata, bus_b.d_valid, bus_b.d_resp};
    return {bus_a.address_mem, bus_a.ren_mem, bus_a.wen_mem, bus_a.wmask_mem, bus_a.wdata_mem,
            bus_a.i_rdata, bus_a.i_valid, bus_a.i_resp, bus_a.d_rdata, bus_a.d_valid, bus_a.d_resp};
  endfunction

  task automatic clear_inputs();
    bus_a.i_req = 1'b0; bus_a.i_addr = '0; bus_a.d_ren = 1'b0; bus_a.d_wen = 1'b0;
    bus_a.d_addr = '0; bus_a.d_wmask = '0; bus_a.d_wdata = '0;
    bus_a.rdata_mem = '0; bus_a.valid_mem = 1'b0; bus_a.resp_mem = '0;
    bus_b.i_req = 1'b0; bus_b.i_addr = '0; bus_b.d_ren = 1'b0; bus_b.d_wen = 1'b0;
    bus_b.d_addr = '0; bus_b.d_wmask = '0; bus_b.d_wdata = '0;
    bus_b.rdata_mem = '0; bus_b.valid_mem = 1'b0; bus_b.resp_mem = '0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  // Waits up to maxc negedges for a bridge request; cyc = negedges waited, -1 on timeout.
  task automatic wait_req(input bit sel, input int maxc, output int cyc);
    cyc = -1;
    for (int c = 1; c <= maxc; c++) begin
      @(negedge clk);
      if (sel ? (bus_b.ren_mem | bus_b.wen_mem) : (bus_a.ren_mem | bus_a.wen_mem)) begin
        cyc = c;
        break;
      end
    end
  endtask

  // Bridge completion: valid_mem for one cycle with data and response.
  task automatic bridge_done(input bit sel, input logic [DW-1:0] rd, input logic [1:0] rs);
    if (sel) begin bus_b.valid_mem = 1'b1; bus_b.rdata_mem = rd; bus_b.resp_mem = rs; end
    else     begin bus_a.valid_mem = 1'b1; bus_a.rdata_mem = rd; bus_a.resp_mem = rs; end
    @(negedge clk);
    bus_a.valid_mem = 1'b0;
    bus_b.valid_mem = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    clear_inputs();
    bus_a.i_req = 1'b1;
    bus_b.d_wen = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (outs(0) !== '0) begin errors++; $display("FAIL reset_a: got %h required 0", outs(0)); end
    checks++; if (outs(1) !== '0) begin errors++; $display("FAIL reset_b: got %h required 0", outs(1)); end
    clear_inputs();
    rstn = 1'b1;
    @(negedge clk);
    checks++; if (outs(0) !== '0) begin errors++; $display("FAIL reset_idle_a: got %h required 0", outs(0)); end
  endtask

  task automatic test_single_fetch();
    int cyc;
    bus_a.i_addr = 64'h8000_0000;
    bus_a.i_req  = 1'b1;
    wait_req(0, 4, cyc);
    checks++; if (cyc != 1) begin errors++; $display("FAIL fetch_latency: got %0d required 1", cyc); end
    checks++; if ({bus_a.ren_mem, bus_a.wen_mem} !== 2'b10) begin errors++; $display("FAIL fetch_ren_wen: got %b required 10", {bus_a.ren_mem, bus_a.wen_mem}); end
    checks++; if (bus_a.address_mem !== 64'h8000_0000) begin errors++; $display("FAIL fetch_addr: got %h required 80000000", bus_a.address_mem); end
    checks++; if (bus_a.wmask_mem !== '0) begin errors++; $display("FAIL fetch_wmask: got %h required 0", bus_a.wmask_mem); end
    @(negedge clk);
    checks++; if ({bus_a.ren_mem, bus_a.i_valid} !== 2'b10) begin errors++; $display("FAIL fetch_hold: got %b required 10", {bus_a.ren_mem, bus_a.i_valid}); end
    bridge_done(0, 64'h0000_0013_0000_0093, 2'b00);
    checks++; if (bus_a.i_valid !== 1'b1) begin errors++; $display("FAIL fetch_valid: got %b required 1", bus_a.i_valid); end
    checks++; if (bus_a.i_rdata !== 64'h0000_0013_0000_0093) begin errors++; $display("FAIL fetch_rdata: got %h required 0000001300000093", bus_a.i_rdata); end
    checks++; if (bus_a.i_resp !== 2'b00) begin errors++; $display("FAIL fetch_resp: got %b required 00", bus_a.i_resp); end
    checks++; if (bus_a.d_valid !== 1'b0) begin errors++; $display("FAIL fetch_dvalid: got %b required 0", bus_a.d_valid); end
    bus_a.i_req = 1'b0;
    @(negedge clk);
    checks++; if ({bus_a.i_valid, bus_a.ren_mem} !== 2'b00) begin errors++; $display("FAIL fetch_pulse_end: got %b required 00", {bus_a.i_valid, bus_a.ren_mem}); end
    checks++; if (bus_a.i_rdata !== 64'h0000_0013_0000_0093) begin errors++; $display("FAIL fetch_rdata_hold: got %h", bus_a.i_rdata); end
    // stray valid_mem while idle must be ignored
    bridge_done(0, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11);
    @(negedge clk);
    checks++; if ({bus_a.i_valid, bus_a.d_valid, bus_a.ren_mem, bus_a.wen_mem} !== 4'b0000) begin errors++; $display("FAIL idle_valid_ignored: got %b required 0000", {bus_a.i_valid, bus_a.d_valid, bus_a.ren_mem, bus_a.wen_mem}); end
    checks++; if (bus_a.i_rdata !== 64'h0000_0013_0000_0093) begin errors++; $display("FAIL idle_rdata_kept: got %h", bus_a.i_rdata); end
  endtask

  task automatic test_single_store();
    int cyc;
    logic [DW-1:0] rd;
    bus_a.d_addr  = 64'h1000;
    bus_a.d_wmask = 8'h0F;
    bus_a.d_wdata = 64'hDEAD_BEEF;
    bus_a.d_wen   = 1'b1;
    wait_req(0, 4, cyc);
    checks++; if (cyc != 1) begin errors++; $display("FAIL store_latency: got %0d required 1", cyc); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({bus_a.wen_mem, bus_a.ren_mem, bus_a.address_mem, bus_a.wmask_mem, bus_a.wdata_mem} !==
          {2'b10, 64'h1000, 8'h0F, 64'hDEAD_BEEF}) begin
        errors++;
        $display("FAIL store_hold[%0d]: got wen=%b ren=%b addr=%h mask=%h data=%h required 1 0 1000 0f deadbeef",
                 k, bus_a.wen_mem, bus_a.ren_mem, bus_a.address_mem, bus_a.wmask_mem, bus_a.wdata_mem);
      end
      if (k < 2) @(negedge clk);
    end
    rd = {$urandom, $urandom};
    bridge_done(0, rd, 2'b10);
    checks++; if (bus_a.wen_mem !== 1'b0) begin errors++; $display("FAIL store_wen_drop: got %b required 0", bus_a.wen_mem); end
    checks++; if (bus_a.d_valid !== 1'b1) begin errors++; $display("FAIL store_valid: got %b required 1", bus_a.d_valid); end
    checks++; if (bus_a.d_resp !== 2'b10) begin errors++; $display("FAIL store_resp: got %b required 10", bus_a.d_resp); end
    checks++; if (bus_a.i_valid !== 1'b0) begin errors++; $display("FAIL store_ivalid: got %b required 0", bus_a.i_valid); end
    bus_a.d_wen = 1'b0;
    @(negedge clk);
    checks++; if ({bus_a.d_valid, bus_a.d_resp} !== 3'b010) begin errors++; $display("FAIL store_resp_hold: got %b required 010", {bus_a.d_valid, bus_a.d_resp}); end
  endtask

  task automatic test_fair();
    int cyc;
    bit exp_d;
    do_reset();
    bus_a.i_addr  = 64'h8000_0100;
    bus_a.d_addr  = 64'h2000;
    bus_a.d_wmask = 8'hFF;
    bus_a.d_wdata = {$urandom, $urandom};
    bus_a.i_req   = 1'b1;
    bus_a.d_wen   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_d = (k % 2 == 0);
      wait_req(0, 4, cyc);
      checks++; if (cyc != ((k == 0) ? 1 : 2)) begin errors++; $display("FAIL fair_gap[%0d]: got %0d required %0d", k, cyc, (k == 0) ? 1 : 2); end
      checks++;
      if ({bus_a.wen_mem, bus_a.ren_mem} !== {exp_d, !exp_d} ||
          bus_a.address_mem !== (exp_d ? bus_a.d_addr : bus_a.i_addr)) begin
        errors++;
        $display("FAIL fair_order[%0d]: got wen=%b ren=%b addr=%h required grant %s", k,
                 bus_a.wen_mem, bus_a.ren_mem, bus_a.address_mem, exp_d ? "D" : "I");
      end
      bridge_done(0, {$urandom, $urandom}, 2'b00);
      checks++;
      if ({bus_a.d_valid, bus_a.i_valid, bus_a.ren_mem, bus_a.wen_mem} !== {exp_d, !exp_d, 2'b00}) begin
        errors++;
        $display("FAIL fair_valid[%0d]: got dv=%b iv=%b ren=%b wen=%b required dv=%b iv=%b 0 0", k,
                 bus_a.d_valid, bus_a.i_valid, bus_a.ren_mem, bus_a.wen_mem, exp_d, !exp_d);
      end
    end
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_fair0();
    int cyc;
    bit exp_d;
    do_reset();
    bus_b.i_addr = 64'h8000_0200;
    bus_b.d_addr = 64'h2100;
    bus_b.i_req  = 1'b1;
    bus_b.d_ren  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_d = (k < 2);
      wait_req(1, 4, cyc);
      checks++;
      if (cyc < 0 || {bus_b.ren_mem, bus_b.address_mem} !== {1'b1, exp_d ? 64'h2100 : 64'h8000_0200}) begin
        errors++;
        $display("FAIL fixed_order[%0d]: got cyc=%0d ren=%b addr=%h required grant %s", k, cyc,
                 bus_b.ren_mem, bus_b.address_mem, exp_d ? "D" : "I");
      end
      bridge_done(1, {$urandom, $urandom}, 2'b00);
      checks++;
      if ({bus_b.d_valid, bus_b.i_valid} !== {exp_d, !exp_d}) begin
        errors++;
        $display("FAIL fixed_valid[%0d]: got dv=%b iv=%b required dv=%b iv=%b", k,
                 bus_b.d_valid, bus_b.i_valid, exp_d, !exp_d);
      end
      if (k == 1) bus_b.d_ren = 1'b0;
    end
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic [DW-1:0] rd;
    bus_a.d_addr  = 64'h3000;
    bus_a.d_wmask = 8'hF0;
    bus_a.d_wdata = {$urandom, $urandom};
    bus_a.d_wen   = 1'b1;
    wait_req(0, 4, cyc);
    checks++; if (bus_a.wen_mem !== 1'b1) begin errors++; $display("FAIL rstmid_grant: got %b required 1", bus_a.wen_mem); end
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    checks++; if (outs(0) !== '0) begin errors++; $display("FAIL rstmid_outputs: got %h required 0", outs(0)); end
    rstn = 1'b1;
    bus_a.d_wen  = 1'b0;
    bus_a.i_addr = 64'h8000_0400;
    bus_a.i_req  = 1'b1;
    wait_req(0, 4, cyc);
    checks++; if (cyc != 1 || bus_a.ren_mem !== 1'b1 || bus_a.address_mem !== 64'h8000_0400) begin errors++; $display("FAIL rstmid_refetch: got cyc=%0d ren=%b addr=%h required 1 1 80000400", cyc, bus_a.ren_mem, bus_a.address_mem); end
    rd = {$urandom, $urandom};
    bridge_done(0, rd, 2'b00);
    checks++; if ({bus_a.i_valid, bus_a.d_valid, bus_a.i_rdata} !== {2'b10, rd}) begin errors++; $display("FAIL rstmid_complete: got iv=%b dv=%b rdata=%h required 1 0 %h", bus_a.i_valid, bus_a.d_valid, bus_a.i_rdata, rd); end
    bus_a.i_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_illegal();
    int cyc;
    logic [DW-1:0] rd;
    bus_a.d_addr  = 64'h4000;
    bus_a.d_wmask = 8'h3C;
    bus_a.d_wdata = {$urandom, $urandom};
    bus_a.d_ren   = 1'b1;
    bus_a.d_wen   = 1'b1;
    wait_req(0, 4, cyc);
    checks++; if ({bus_a.wen_mem, bus_a.ren_mem} !== 2'b10) begin errors++; $display("FAIL illegal_rw: got wen=%b ren=%b required 1 0", bus_a.wen_mem, bus_a.ren_mem); end
    rd = {$urandom, $urandom};
    bridge_done(0, rd, 2'b00);
    checks++; if ({bus_a.d_valid, bus_a.d_rdata} !== {1'b1, rd}) begin errors++; $display("FAIL illegal_done: got dv=%b rdata=%h required 1 %h", bus_a.d_valid, bus_a.d_rdata, rd); end
    clear_inputs();
    @(negedge clk);
  endtask

  // Randomized traffic on the FAIR=1 instance against a transaction-level model:
  // each requester holds a pending request; ties go to the side not served last.
  task automatic test_random();
    bit ip, dp, w, dw, lg;
    logic [AW-1:0] ia, da, ea;
    logic [SW-1:0] dm, em;
    logic [DW-1:0] dd, ed, rd;
    logic [1:0] rs;
    logic [DW-1:0] last_rd [2];
    logic [1:0] last_rs [2];
    bit eren, ewen;
    int cyc, exp_cyc, lat;
    do_reset();
    ip = 0; dp = 0; lg = 0; exp_cyc = 1;
    last_rd[0] = '0; last_rd[1] = '0; last_rs[0] = '0; last_rs[1] = '0;
    for (int n = 0; n < 40; n++) begin
      if (!ip && $urandom_range(0, 1) == 1) begin
        ip = 1; ia = {$urandom, $urandom};
        bus_a.i_addr = ia; bus_a.i_req = 1'b1;
      end
      if (!dp && ($urandom_range(0, 1) == 1 || !ip)) begin
        dp = 1; da = {$urandom, $urandom}; dw = $urandom_range(0, 1) == 1;
        dm = SW'($urandom); dd = {$urandom, $urandom};
        bus_a.d_addr = da; bus_a.d_wmask = dm; bus_a.d_wdata = dd;
        bus_a.d_wen = dw; bus_a.d_ren = !dw;
      end
      w  = (ip && dp) ? !lg : dp;
      lg = w;
      if (w) begin ea = da; eren = !dw; ewen = dw; em = dm; ed = dd; end
      else   begin ea = ia; eren = 1'b1; ewen = 1'b0; em = '0; ed = '0; end
      wait_req(0, 4, cyc);
      checks++; if (cyc != exp_cyc) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d required %0d", n, cyc, exp_cyc); end
      checks++;
      if ({bus_a.ren_mem, bus_a.wen_mem, bus_a.address_mem, bus_a.wmask_mem} !== {eren, ewen, ea, em} ||
          (w && bus_a.wdata_mem !== ed)) begin
        errors++;
        $display("FAIL rnd_issue[%0d]: got ren=%b wen=%b addr=%h mask=%h data=%h required %b %b %h %h %h",
                 n, bus_a.ren_mem, bus_a.wen_mem, bus_a.address_mem, bus_a.wmask_mem, bus_a.wdata_mem,
                 eren, ewen, ea, em, ed);
      end
      if (w) begin bus_a.d_addr = {$urandom, $urandom}; bus_a.d_wdata = {$urandom, $urandom}; end
      else   bus_a.i_addr = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) begin
        if (w) begin dp = 0; bus_a.d_ren = 1'b0; bus_a.d_wen = 1'b0; end
        else   begin ip = 0; bus_a.i_req = 1'b0; end
      end
      lat = $urandom_range(0, 3);
      for (int k = 0; k < lat; k++) begin
        @(negedge clk);
        checks++;
        if ({bus_a.ren_mem, bus_a.wen_mem, bus_a.address_mem, bus_a.wmask_mem} !== {eren, ewen, ea, em} ||
            bus_a.i_valid !== 1'b0 || bus_a.d_valid !== 1'b0) begin
          errors++;
          $display("FAIL rnd_hold[%0d.%0d]: got ren=%b wen=%b addr=%h mask=%h iv=%b dv=%b required %b %b %h %h 0 0",
                   n, k, bus_a.ren_mem, bus_a.wen_mem, bus_a.address_mem, bus_a.wmask_mem,
                   bus_a.i_valid, bus_a.d_valid, eren, ewen, ea, em);
        end
      end
      rd = {$urandom, $urandom};
      rs = 2'($urandom_range(0, 3));
      bridge_done(0, rd, rs);
      checks++;
      if ({bus_a.i_valid, bus_a.d_valid, bus_a.ren_mem, bus_a.wen_mem} !== {!w, w, 2'b00}) begin
        errors++;
        $display("FAIL rnd_pulse[%0d]: got iv=%b dv=%b ren=%b wen=%b required %b %b 0 0",
                 n, bus_a.i_valid, bus_a.d_valid, bus_a.ren_mem, bus_a.wen_mem, !w, w);
      end
      checks++;
      if ((w ? {bus_a.d_rdata, bus_a.d_resp, bus_a.i_rdata, bus_a.i_resp}
             : {bus_a.i_rdata, bus_a.i_resp, bus_a.d_rdata, bus_a.d_resp}) !== {rd, rs, last_rd[!w], last_rs[!w]}) begin
        errors++;
        $display("FAIL rnd_data[%0d]: got i=%h/%b d=%h/%b winner %s required %h/%b other %h/%b",
                 n, bus_a.i_rdata, bus_a.i_resp, bus_a.d_rdata, bus_a.d_resp, w ? "D" : "I",
                 rd, rs, last_rd[!w], last_rs[!w]);
      end
      last_rd[w] = rd;
      last_rs[w] = rs;
      if (w) begin dp = 0; bus_a.d_ren = 1'b0; bus_a.d_wen = 1'b0; end
      else   begin ip = 0; bus_a.i_req = 1'b0; end
      exp_cyc = 2;
    end
    clear_inputs();
    @(negedge clk);
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_fetch();
    test_single_store();
    test_fair();
    test_fair0();
    test_reset_mid();
    test_illegal();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single mem-side port of the AXI-lite master bridge between the instruction-fetch requester (read-only, "i") and the data requester (read/write, "d") of the pipeline CPU.
- Arbitrates between the two requesters, registers the winning request onto the bridge port and holds it until the bridge pulses valid_mem.
- Drops the bridge request so the bridge cannot re-issue it, then returns read data and response to the winner with a one-cycle valid pulse.

Parameters:
- ADDR_W, 64, address width (matches bridge).
- DATA_W, 64, data width; strobe width is DATA_W/8.
- FAIR, 1, 1 = alternate grants on simultaneous requests; 0 = d always wins ties.

Ports:
- clk  in  1  single clock.
- rstn  in  1  synchronous active-low reset.
- i_req  in  1  instruction read request; held until i_valid.
- i_addr  in  ADDR_W  fetch address.
- i_rdata  out  DATA_W  fetch data, valid with i_valid.
- i_valid  out  1  one-cycle completion pulse.
- i_resp  out  2  AXI response for the fetch.
- d_ren  in  1  data read request; held until d_valid.
- d_wen  in  1  data write request; held until d_valid.
- d_addr  in  ADDR_W  data address.
- d_wmask  in  DATA_W/8  byte strobes.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data, valid with d_valid.
- d_valid  out  1  one-cycle completion pulse.
- d_resp  out  2  AXI response.
- address_mem  out  ADDR_W  to bridge.
- ren_mem  out  1  to bridge.
- wen_mem  out  1  to bridge.
- wmask_mem  out  DATA_W/8  to bridge.
- wdata_mem  out  DATA_W  to bridge.
- rdata_mem  in  DATA_W  from bridge.
- valid_mem  in  1  from bridge; one-cycle completion pulse.
- resp_mem  in  2  from bridge; registered, updated on the valid_mem edge.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous, active-low on rstn.
- Reset values: all outputs 0; state IDLE; last_grant = I.
- States:
  - IDLE: sample requests. d_active = d_ren|d_wen.
    - Both i_req and d_active: FAIR=0 grants D; FAIR=1 grants the side not equal to last_grant.
    - Single request: grant that side.
    - On grant, register address/mask/wdata and ren_mem/wen_mem; go to GNT_I or GNT_D; update last_grant.
  - GNT_I / GNT_D: hold all bridge outputs stable.
    - When valid_mem=1: latch rdata_mem into the winner's rdata register, clear ren_mem/wen_mem, go to RESP.
    - wen_mem stays high through the valid_mem cycle, because the bridge selects bresp vs rresp using it.
  - RESP: assert the winner's valid for exactly one cycle; winner's resp = resp_mem (value sampled this cycle). Next state IDLE.
- Grant rules:
  - No new grant in RESP. Minimum request-to-request spacing on the bridge is 1 cycle with ren/wen low.
  - GNT_I drives ren_mem=1, wen_mem=0, wmask_mem=0.
  - d_ren & d_wen both high is illegal; the write is issued (wen_mem=1, ren_mem=0). Flagged by an assertion.
- Latency: request seen in IDLE at cycle t → bridge request visible at t+1 → valid_mem at cycle v → requester valid at v+1.
- Requests are sampled only at grant; later changes to addr/data are ignored until RESP.
- Requester drops its request mid-transaction: the transaction still completes; the valid pulse is still issued and the requester ignores it.
- rdata/resp outputs hold their last value between pulses. The non-winner's valid stays 0.
- valid_mem in IDLE or RESP: ignored, no state change.
- Reset mid-transaction: immediate return to IDLE with all outputs 0. The bridge shares rstn, so no completion is owed.

Decomposition:
- Shared package mem_arb_pkg:
  - state enum {IDLE, GNT_I, GNT_D, RESP};
  - grant enum {GRANT_I, GRANT_D};
  - localparam RESP_OKAY=2'b00.
- Natural sub-module: mem_arb_pick, the combinational two-way fixed/round-robin selector taking i_req, d_active, last_grant, FAIR and returning grant_i/grant_d. All else in one module.

Test Plan:
- Single fetch: i_req=1, i_addr=0x8000_0000; bridge returns rdata 0x0000_0013_0000_0093, OKAY.
  - Required: ren_mem one cycle after the request, address 0x8000_0000; i_valid one cycle after valid_mem; i_rdata equals the returned data; i_resp=0; d_valid stays 0.
- Single store: d_wen=1, addr 0x1000, wmask 0x0F, wdata 0xDEADBEEF.
  - Required: wen_mem held with identical fields through the valid_mem cycle, then 0.
  - d_valid one cycle later; d_resp = bresp (drive 2'b10 → d_resp=2'b10).
- Simultaneous requests, FAIR=1, both held for 4 transactions.
  - Required grant order D,I,D,I (last_grant=I after reset).
  - FAIR=0: D served first and I only after d drops.
- Back-to-back: after valid_mem, ren_mem/wen_mem=0 for exactly one cycle (RESP) before the next grant; bridge never sees a duplicate transaction.
- Reset mid-transaction: rstn=0 while in GNT_D.
  - Required: next cycle all outputs 0 and state IDLE; a fresh i_req afterwards completes normally.
- Illegal d_ren&d_wen: write issued, ren_mem=0, assertion fires.
